// File: rtl/serial_aors.sv
// Bit-serial add/subtract unit: one bit per clock, LSB first, with carry/borrow and signed
// overflow, start/busy/done handshake and an accumulate mode that feeds the last result back.
module serial_aors #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             s_i,
    input  logic             acc_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH:0]   out_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
    logic             carry_q, carry_d, sub_q, sub_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   out_q, out_d;
    logic             ovf_q, ovf_d, done_q, done_d;

    logic b_bit, sum_bit, carry_nxt, last_bit;

    // Subtraction is x + ~y + 1: invert each B bit and seed the carry with 1.
    assign b_bit     = b_q[0] ^ sub_q;
    assign sum_bit   = a_q[0] ^ b_bit ^ carry_q;
    assign carry_nxt = (a_q[0] & b_bit) | (a_q[0] & carry_q) | (b_bit & carry_q);
    assign last_bit  = (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i)  state_d = StRun;
            StRun:  if (last_bit) state_d = StIdle;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        if (state_q == StIdle) begin
            if (start_i) begin
                a_d     = x_i;
                b_d     = acc_i ? out_q[WIDTH-1:0] : y_i;
                sub_d   = s_i;
                carry_d = s_i;
                cnt_d   = '0;
            end
        end else begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            sh_d    = {sum_bit, sh_q[WIDTH-1:1]};
            carry_d = carry_nxt;
            cnt_d   = cnt_q + CntW'(1);
            if (last_bit) begin
                // carry_q here is the carry into the MSB; bit WIDTH reports borrow when subtracting.
                out_d  = {carry_nxt ^ sub_q, sum_bit, sh_q[WIDTH-1:1]};
                ovf_d  = carry_q ^ carry_nxt;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        busy_o = (state_q == StRun);
        done_o = done_q;
        out_o  = out_q;
        ovf_o  = ovf_q;
    end

endmodule

// File: tb/tb_serial_aors.sv
// Bench for serial_aors: directed WIDTH=4 cases and protocol checks, random WIDTH=8 traffic,
// all compared every cycle against an arithmetic reference model.
module tb_serial_aors;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WIDTH=4 instance
    logic       rst4_n;
    logic       start4 = 1'b0, s4 = 1'b0, acc4 = 1'b0;
    logic [3:0] x4 = '0, y4 = '0;
    logic       busy4, done4, ovf4;
    logic [4:0] out4;

    // WIDTH=8 instance
    logic       rst8_n;
    logic       start8 = 1'b0, s8 = 1'b0, acc8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;
    logic       busy8, done8, ovf8;
    logic [8:0] out8;

    serial_aors #(.WIDTH(4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst4_n), .start_i(start4), .x_i(x4), .y_i(y4), .s_i(s4),
        .acc_i(acc4), .busy_o(busy4), .done_o(done4), .out_o(out4), .ovf_o(ovf4)
    );

    serial_aors #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .rst_ni(rst8_n), .start_i(start8), .x_i(x8), .y_i(y8), .s_i(s8),
        .acc_i(acc8), .busy_o(busy8), .done_o(done8), .out_o(out8), .ovf_o(ovf8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // {ovf, carry/borrow, sum} from plain integer arithmetic.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a,
                                           input logic [31:0] b, input logic sub);
        logic [63:0] m, r;
        logic        cb, ov, sa, sb, sr;
        m = (64'd1 << w) - 64'd1;
        if (sub) begin
            r  = ({32'd0, a} - {32'd0, b}) & m;
            cb = (a < b);
        end else begin
            r  = {32'd0, a} + {32'd0, b};
            cb = r[w];
            r  = r & m;
        end
        sa = a[w-1];
        sb = b[w-1];
        sr = r[w-1];
        ov = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        r  = r | ({63'd0, cb} << w);
        return {ov, r[32:0]};
    endfunction

    // Reference model: an op accepted when idle completes WIDTH edges later.
    logic [4:0]  m4_out;
    logic        m4_ovf, m4_done;
    int          m4_rem;
    logic [33:0] m4_pend;

    always @(posedge clk or negedge rst4_n) begin
        if (!rst4_n) begin
            m4_out <= '0; m4_ovf <= 1'b0; m4_done <= 1'b0; m4_rem <= 0;
        end else begin
            m4_done <= 1'b0;
            if (m4_rem > 0) begin
                m4_rem <= m4_rem - 1;
                if (m4_rem == 1) begin
                    m4_done <= 1'b1;
                    m4_out  <= m4_pend[4:0];
                    m4_ovf  <= m4_pend[33];
                end
            end else if (start4) begin
                m4_pend <= ref_op(4, 32'(x4), acc4 ? 32'(m4_out[3:0]) : 32'(y4), s4);
                m4_rem  <= 4;
            end
        end
    end

    logic [8:0]  m8_out;
    logic        m8_ovf, m8_done;
    int          m8_rem;
    int          m8_nops;
    logic [33:0] m8_pend;

    always @(posedge clk or negedge rst8_n) begin
        if (!rst8_n) begin
            m8_out <= '0; m8_ovf <= 1'b0; m8_done <= 1'b0; m8_rem <= 0;
        end else begin
            m8_done <= 1'b0;
            if (m8_rem > 0) begin
                m8_rem <= m8_rem - 1;
                if (m8_rem == 1) begin
                    m8_done <= 1'b1;
                    m8_out  <= m8_pend[8:0];
                    m8_ovf  <= m8_pend[33];
                    m8_nops <= m8_nops + 1;
                end
            end else if (start8) begin
                m8_pend <= ref_op(8, 32'(x8), acc8 ? 32'(m8_out[7:0]) : 32'(y8), s8);
                m8_rem  <= 8;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy4", busy4, m4_rem != 0);
        chk("done4", done4, m4_done);
        chk("out4",  out4,  m4_out);
        chk("ovf4",  ovf4,  m4_ovf);
        chk("busy8", busy8, m8_rem != 0);
        chk("done8", done8, m8_done);
        chk("out8",  out8,  m8_out);
        chk("ovf8",  ovf8,  m8_ovf);
    end

    task automatic op4(input logic [3:0] xv, input logic [3:0] yv, input logic sv,
                       input logic accv, input logic [4:0] eo, input logic eov, input string nm);
        int n;
        @(negedge clk);
        start4 = 1'b1; x4 = xv; y4 = yv; s4 = sv; acc4 = accv;
        @(posedge clk); #1;
        start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom); s4 = 1'($urandom);
        acc4 = 1'($urandom);
        n = 0;
        while (!done4 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 4);
        chk({nm, "_out"}, out4, eo);
        chk({nm, "_ovf"}, ovf4, eov);
    endtask

    task automatic count_done4(input int cycles, output int cnt, output int first_gap_bad);
        int last;
        cnt = 0; last = -1; first_gap_bad = 0;
        for (int i = 1; i <= cycles; i++) begin
            @(posedge clk); #1;
            if (done4) begin
                if (last >= 0 && (i - last) != 5) first_gap_bad++;
                last = i;
                cnt++;
            end
        end
    endtask

    task automatic reset4();
        @(negedge clk); rst4_n = 1'b0;
        @(negedge clk); rst4_n = 1'b1;
    endtask

    initial begin
        int cnt, bad, cyc;
        rst4_n = 1'b0;
        rst8_n = 1'b0;
        m8_nops = 0;
        #1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_out",  out4,  0);
        chk("rst_ovf",  ovf4,  0);
        repeat (2) @(negedge clk);
        rst4_n = 1'b1;
        rst8_n = 1'b1;

        op4(4'b1101, 4'b1011, 1'b1, 1'b0, 5'b0_0010, 1'b0, "sub_13_11");
        op4(4'b0111, 4'b0101, 1'b0, 1'b0, 5'b0_1100, 1'b1, "add_7_5");
        op4(4'b1010, 4'b0110, 1'b0, 1'b0, 5'b1_0000, 1'b0, "add_10_6");
        op4(4'b0111, 4'b0101, 1'b1, 1'b0, 5'b0_0010, 1'b0, "sub_7_5");
        op4(4'b0101, 4'b0111, 1'b1, 1'b0, 5'b1_1110, 1'b0, "sub_5_7");

        // start pulsed while running must not spawn a second op
        @(negedge clk); start4 = 1'b1; x4 = 4'd3; y4 = 4'd4; s4 = 1'b0; acc4 = 1'b0;
        @(negedge clk); start4 = 1'b0;
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        count_done4(10, cnt, bad);
        chk("start_in_run_dones", cnt, 1);

        // start held high: done every WIDTH+1 cycles
        @(negedge clk); start4 = 1'b1; x4 = 4'd1; y4 = 4'd2; s4 = 1'b0; acc4 = 1'b0;
        count_done4(25, cnt, bad);
        chk("held_start_dones", cnt, 5);
        chk("held_start_gap", bad, 0);
        @(negedge clk); start4 = 1'b0;
        repeat (6) @(negedge clk);

        // asynchronous reset in the middle of an op
        @(negedge clk); start4 = 1'b1; x4 = 4'd5; y4 = 4'd3; s4 = 1'b0; acc4 = 1'b0;
        @(posedge clk); #1; start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst4_n = 1'b0;
        #1;
        chk("midrst_busy", busy4, 0);
        chk("midrst_done", done4, 0);
        chk("midrst_out",  out4,  0);
        chk("midrst_ovf",  ovf4,  0);
        @(negedge clk); @(negedge clk); rst4_n = 1'b1;
        count_done4(6, cnt, bad);
        chk("midrst_no_done", cnt, 0);
        op4(4'b1001, 4'b0011, 1'b1, 1'b0, 5'b0_0110, 1'b1, "after_rst_sub_9_3");

        // accumulate chain starting from the reset value of out
        reset4();
        op4(4'b0011, 4'b1111, 1'b0, 1'b1, 5'b0_0011, 1'b0, "acc1");
        op4(4'b0011, 4'b1010, 1'b0, 1'b1, 5'b0_0110, 1'b0, "acc2");
        op4(4'b0011, 4'b0101, 1'b0, 1'b1, 5'b0_1001, 1'b1, "acc3");

        // random traffic on the WIDTH=8 instance
        cyc = 0;
        while (m8_nops < 1000 && cyc < 30000) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) != 0);
            x8     = 8'($urandom);
            y8     = 8'($urandom);
            s8     = 1'($urandom);
            acc8   = ($urandom_range(0, 7) == 0);
            cyc++;
        end
        chk("random_ops_completed", m8_nops >= 1000, 1);
        @(negedge clk); start8 = 1'b0;
        repeat (12) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
